// File: rtl/req_sched_1r1wor2w.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : req_sched_1r1wor2w                                              |
// | Brief    : Round-robin scheduler, NUMREQ requesters onto a 1R1W-or-2W      |
// |            memory port, with read-return tag tracking.                     |
// | Option   : `define SCHED_STALL_CNT_EN enables the saturating stall counter |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module req_sched_1r1wor2w #(
    parameter int NUMREQ   = 4,
    parameter int BITREQ   = 2,
    parameter int WIDTH    = 32,
    parameter int BITADDR  = 13,
    parameter int READ_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUMREQ-1:0]         req_vld,
    input  logic [NUMREQ-1:0]         req_wr,
    input  logic [NUMREQ*BITADDR-1:0] req_addr,
    input  logic [NUMREQ*WIDTH-1:0]   req_din,
    output logic [NUMREQ-1:0]         req_rdy,
    input  logic                      ready,
    output logic                      read,
    output logic [1:0]                write,
    output logic [2*BITADDR-1:0]      addr,
    output logic [2*WIDTH-1:0]        din,
    input  logic                      rd_vld,
    input  logic [WIDTH-1:0]          rd_dout,
    input  logic                      rd_err,
    output logic [NUMREQ-1:0]         rsp_vld,
    output logic [WIDTH-1:0]          rsp_dout,
    output logic                      rsp_err,
    output logic                      seq_err,
    output logic [15:0]               stall_cnt
);

    logic                 read_q,   read_d;
    logic [1:0]           write_q,  write_d;
    logic [2*BITADDR-1:0] addr_q,   addr_d;
    logic [2*WIDTH-1:0]   din_q,    din_d;
    logic [BITREQ-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BITREQ-1:0]    rd_id_q,  rd_id_d;
    logic                 tag_vld_q [READ_LAT];
    logic [BITREQ-1:0]    tag_id_q  [READ_LAT];
    logic                 seq_err_q;
    logic                 tag_out_vld;
    logic [BITREQ-1:0]    tag_out_id;

    // Scan requesters from rr_ptr; at most two grants, one read, distinct addresses.
    always_comb begin : p_grant
        int                 idx;
        logic [1:0]         gnt_cnt;
        logic               rd_gnt;
        logic               slot1_used;
        logic [BITADDR-1:0] first_addr;
        logic [BITADDR-1:0] cur_addr;
        req_rdy    = '0;
        read_d     = 1'b0;
        write_d    = 2'b00;
        addr_d     = addr_q;
        din_d      = din_q;
        rr_ptr_d   = rr_ptr_q;
        rd_id_d    = rd_id_q;
        idx        = 0;
        gnt_cnt    = 2'd0;
        rd_gnt     = 1'b0;
        slot1_used = 1'b0;
        first_addr = '0;
        cur_addr   = '0;
        if (rst && ready) begin
            for (int k = 0; k < NUMREQ; k++) begin
                idx      = (int'(rr_ptr_q) + k) % NUMREQ;
                cur_addr = req_addr[idx*BITADDR +: BITADDR];
                if (req_vld[idx] && (gnt_cnt < 2'd2) && !(!req_wr[idx] && rd_gnt)
                    && !((gnt_cnt == 2'd1) && (cur_addr == first_addr))) begin
                    req_rdy[idx] = 1'b1;
                    if (gnt_cnt == 2'd0) begin
                        first_addr = cur_addr;
                    end
                    gnt_cnt  = gnt_cnt + 2'd1;
                    rr_ptr_d = BITREQ'((idx + 1) % NUMREQ);
                    if (!req_wr[idx]) begin
                        rd_gnt              = 1'b1;
                        read_d              = 1'b1;
                        rd_id_d             = BITREQ'(idx);
                        addr_d[0 +: BITADDR] = cur_addr;
                    end else if (!slot1_used) begin
                        slot1_used                 = 1'b1;
                        write_d[1]                 = 1'b1;
                        addr_d[BITADDR +: BITADDR] = cur_addr;
                        din_d[WIDTH +: WIDTH]      = req_din[idx*WIDTH +: WIDTH];
                    end else begin
                        // Slot 1 already holds a write, so no read can be in slot 0.
                        write_d[0]           = 1'b1;
                        addr_d[0 +: BITADDR] = cur_addr;
                        din_d[0 +: WIDTH]    = req_din[idx*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_q    <= 1'b0;
            write_q   <= 2'b00;
            addr_q    <= '0;
            din_q     <= '0;
            rr_ptr_q  <= '0;
            rd_id_q   <= '0;
            seq_err_q <= 1'b0;
            for (int i = 0; i < READ_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
            end
        end else begin
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            rr_ptr_q     <= rr_ptr_d;
            rd_id_q      <= rd_id_d;
            seq_err_q    <= seq_err_q | (rd_vld ^ tag_out_vld);
            // The tag enters alongside the issued read, so it exits as the data returns.
            tag_vld_q[0] <= read_q;
            tag_id_q[0]  <= rd_id_q;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign tag_out_vld = tag_vld_q[READ_LAT-1];
    assign tag_out_id  = tag_id_q[READ_LAT-1];

    always_comb begin
        rsp_vld = '0;
        if (tag_out_vld && rd_vld) begin
            rsp_vld[tag_out_id] = 1'b1;
        end
    end

    assign rsp_dout = rd_dout;
    assign rsp_err  = rd_err;
    assign seq_err  = seq_err_q;
    assign read     = read_q;
    assign write    = write_q;
    assign addr     = addr_q;
    assign din      = din_q;

`ifdef SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
        end else if (((req_vld & ~req_rdy) != '0) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_sched_1r1wor2w.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_req_sched_1r1wor2w                                           |
// | Brief    : Directed and random bench for req_sched_1r1wor2w with a         |
// |            behavioural scheduling and read-return model.                   |
// | Option   : honours `define SCHED_STALL_CNT_EN for stall_cnt expectations   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_req_sched_1r1wor2w;

    localparam int N  = 4;
    localparam int BR = 2;
    localparam int DW = 32;
    localparam int AW = 13;
    localparam int RL = 3;
`ifdef SCHED_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_din;
    logic [N-1:0]    req_rdy;
    logic            ready;
    logic            read;
    logic [1:0]      write;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] din;
    logic            rd_vld;
    logic [DW-1:0]   rd_dout;
    logic            rd_err;
    logic [N-1:0]    rsp_vld;
    logic [DW-1:0]   rsp_dout;
    logic            rsp_err;
    logic            seq_err;
    logic [15:0]     stall_cnt;

    req_sched_1r1wor2w #(
        .NUMREQ(N), .BITREQ(BR), .WIDTH(DW), .BITADDR(AW), .READ_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
        .req_rdy(req_rdy), .ready(ready),
        .read(read), .write(write), .addr(addr), .din(din),
        .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_err(rd_err),
        .rsp_vld(rsp_vld), .rsp_dout(rsp_dout), .rsp_err(rsp_err),
        .seq_err(seq_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    bit            inject = 1'b0;

    // Reference state: what the memory port and status outputs should show.
    int            m_rr;
    logic          m_read;
    logic [1:0]    m_write;
    logic [AW-1:0] m_addr0, m_addr1;
    logic [DW-1:0] m_din0, m_din1;
    bit            m_seq;
    int            m_stall;
    int            tag_due [int];
    bit            mem_due [int];

    logic [N-1:0]  last_gnt;
    logic [N-1:0]  obs_rdy, obs_rsp;
    logic          obs_read, obs_seq;
    logic [1:0]    obs_write;
    logic [2*AW-1:0] obs_addr;
    logic [15:0]   obs_stall;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_grant(int ptr);
        logic [N-1:0]  g;
        logic [AW-1:0] used_addr [$];
        bit            have_read;
        g         = '0;
        have_read = 1'b0;
        for (int k = 0; k < N; k++) begin
            int i;
            bit clash;
            i     = (ptr + k) % N;
            clash = 1'b0;
            foreach (used_addr[t])
                if (used_addr[t] == req_addr[i*AW +: AW]) clash = 1'b1;
            if (req_vld[i] && used_addr.size() < 2 && !(!req_wr[i] && have_read) && !clash) begin
                g[i] = 1'b1;
                used_addr.push_back(req_addr[i*AW +: AW]);
                if (!req_wr[i]) have_read = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_rr    = 0;
        m_read  = 1'b0;
        m_write = 2'b00;
        m_addr0 = '0;
        m_addr1 = '0;
        m_din0  = '0;
        m_din1  = '0;
        m_seq   = 1'b0;
        m_stall = 0;
        tag_due.delete();
    endtask

    task automatic set_req(int i, bit wr, int a, logic [DW-1:0] d);
        req_vld[i]            = 1'b1;
        req_wr[i]             = wr;
        req_addr[i*AW +: AW]  = AW'(a);
        req_din[i*DW +: DW]   = d;
    endtask

    // One clock cycle: drive memory return, check mid-cycle, advance the model.
    task automatic step();
        logic [N-1:0] g;
        logic [N-1:0] exp_rsp;
        int           order [$];
        bit           tv;
        int           nwr;
        int           i;
        int           rid;
        rd_vld  = mem_due.exists(cyc) || inject;
        rd_dout = $urandom;
        rd_err  = 1'($urandom_range(0, 1));
        #4;
        if (!rst) model_reset();
        g  = (rst && ready) ? model_grant(m_rr) : '0;
        tv = rst && tag_due.exists(cyc);
        exp_rsp = '0;
        if (tv && rd_vld) exp_rsp[tag_due[cyc]] = 1'b1;

        chk("req_rdy",   64'(req_rdy),   64'(g));
        chk("read",      64'(read),      64'(m_read));
        chk("write",     64'(write),     64'(m_write));
        chk("addr",      64'(addr),      64'({m_addr1, m_addr0}));
        chk("din",       64'(din),       64'({m_din1, m_din0}));
        chk("rsp_vld",   64'(rsp_vld),   64'(exp_rsp));
        if (tv && rd_vld) begin
            chk("rsp_dout", 64'(rsp_dout), 64'(rd_dout));
            chk("rsp_err",  64'(rsp_err),  64'(rd_err));
        end
        chk("seq_err",   64'(seq_err),   64'(m_seq));
        chk("stall_cnt", 64'(stall_cnt), STALL_EN ? 64'(m_stall) : 64'd0);

        obs_rdy   = req_rdy;
        obs_rsp   = rsp_vld;
        obs_read  = read;
        obs_write = write;
        obs_addr  = addr;
        obs_seq   = seq_err;
        obs_stall = stall_cnt;
        last_gnt  = g;

        if (rst) begin
            if (rd_vld != tv) m_seq = 1'b1;
            if (((req_vld & ~g) != '0) && m_stall < 65535) m_stall++;
            for (int k = 0; k < N; k++)
                if (g[(m_rr + k) % N]) order.push_back((m_rr + k) % N);
            m_read  = 1'b0;
            m_write = 2'b00;
            nwr     = 0;
            rid     = 0;
            foreach (order[j]) begin
                i = order[j];
                if (!req_wr[i]) begin
                    m_read  = 1'b1;
                    rid     = i;
                    m_addr0 = req_addr[i*AW +: AW];
                end else if (nwr == 0) begin
                    nwr        = 1;
                    m_write[1] = 1'b1;
                    m_addr1    = req_addr[i*AW +: AW];
                    m_din1     = req_din[i*DW +: DW];
                end else begin
                    m_write[0] = 1'b1;
                    m_addr0    = req_addr[i*AW +: AW];
                    m_din0     = req_din[i*DW +: DW];
                end
            end
            if (order.size() != 0) m_rr = (order[order.size()-1] + 1) % N;
            if (m_read) begin
                tag_due[cyc + 1 + RL] = rid;
                mem_due[cyc + 1 + RL] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst      = 1'b0;
        ready    = 1'b1;
        req_vld  = '0;
        req_wr   = '0;
        req_addr = '0;
        req_din  = '0;
        rd_vld   = 1'b0;
        rd_dout  = '0;
        rd_err   = 1'b0;
        model_reset();

        // Reset state with requests pending.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 1, $urandom);
        step();
        step();
        chk("rst_rdy", 64'(obs_rdy), 64'd0);
        rst     = 1'b1;
        req_vld = '0;
        step();

        // All requesters writing distinct addresses: pairs {0,1},{2,3} alternate.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b1, i * 256 + c, $urandom);
            step();
            chk("stream_gnt", 64'(obs_rdy), (c % 2 == 0) ? 64'h3 : 64'hC);
        end
        req_vld = '0;
        step();

        // Read from 1 and write from 2 share a cycle on separate slots.
        set_req(1, 1'b0, 'h010, $urandom);
        set_req(2, 1'b1, 'h020, 32'hCAFE_0020);
        step();
        chk("rw_gnt", 64'(obs_rdy), 64'h6);
        req_vld = '0;
        step();
        chk("rw_read",  64'(obs_read),            64'd1);
        chk("rw_write", 64'(obs_write),           64'h2);
        chk("rw_addr0", 64'(obs_addr[AW-1:0]),    64'h010);
        chk("rw_addr1", 64'(obs_addr[2*AW-1:AW]), 64'h020);
        for (int k = 0; k < RL; k++) step();
        chk("rw_rsp", 64'(obs_rsp), 64'h2);

        // Move the pointer back to 0, then collide two writes on one address.
        set_req(3, 1'b1, 'h077, $urandom);
        step();
        chk("ptr_gnt", 64'(obs_rdy), 64'h8);
        req_vld = '0;
        set_req(0, 1'b1, 'h055, 32'h0000_0A00);
        set_req(3, 1'b1, 'h055, 32'h0000_0A03);
        step();
        chk("clash_first", 64'(obs_rdy), 64'h1);
        req_vld[0] = 1'b0;
        step();
        chk("clash_retry", 64'(obs_rdy), 64'h8);
        req_vld = '0;

        // Two reads: only one per cycle, the second retries.
        set_req(0, 1'b0, 'h100, $urandom);
        set_req(1, 1'b0, 'h104, $urandom);
        step();
        chk("rd2_first", 64'(obs_rdy), 64'h1);
        req_vld[0] = 1'b0;
        step();
        chk("rd2_retry", 64'(obs_rdy), 64'h2);
        req_vld = '0;
        for (int k = 0; k < RL + 2; k++) step();

        // Read in flight across a reset: its late return is a sequence error.
        set_req(2, 1'b0, 'h222, $urandom);
        step();
        req_vld = '0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        chk("flight_rsp", 64'(obs_rsp), 64'd0);
        step();
        chk("flight_seq", 64'(obs_seq), 64'd1);

        // Memory not ready for five cycles.
        rst = 1'b0;
        step();
        rst = 1'b1;
        ready = 1'b0;
        set_req(0, 1'b1, 'h300, $urandom);
        set_req(1, 1'b1, 'h301, $urandom);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_rdy", 64'(obs_rdy), 64'd0);
        end
        ready = 1'b1;
        step();
        chk("stall_val", 64'(obs_stall), STALL_EN ? 64'd5 : 64'd0);
        req_vld = '0;
        for (int k = 0; k < RL + 2; k++) step();

        // Spurious return with nothing outstanding.
        inject = 1'b1;
        step();
        inject = 1'b0;
        chk("spur_rsp", 64'(obs_rsp), 64'd0);
        step();
        chk("spur_seq", 64'(obs_seq), 64'd1);
        for (int k = 0; k < 3; k++) step();
        chk("spur_sticky", 64'(obs_seq), 64'd1);
        rst = 1'b0;
        step();
        chk("spur_clear", 64'(obs_seq), 64'd0);
        rst = 1'b1;
        step();

        // Random traffic with held requests and a small address space.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_vld[i] && $urandom_range(0, 9) < 6)
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
            ready = ($urandom_range(0, 7) != 0);
            step();
            req_vld = req_vld & ~last_gnt;
        end
        req_vld = '0;
        ready   = 1'b1;
        for (int k = 0; k < RL + 2; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/req_sched_1r1wor2w.md
REQ_SCHED_1R1WOR2W -- requirements
Module: req_sched_1r1wor2w

Interface
REQ-001 Parameter NUMREQ, default 4: number of requesters (2..8).
REQ-002 Parameter BITREQ, default 2: clog2(NUMREQ).
REQ-003 Parameter WIDTH, default 32: data width.
REQ-004 Parameter BITADDR, default 13: address width.
REQ-005 Parameter READ_LAT, default 3: fixed cycles from issued read to memory rd_vld.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 req_vld  in  NUMREQ  per-requester request valid.
REQ-009 req_wr  in  NUMREQ  1=write, 0=read.
REQ-010 req_addr  in  NUMREQ*BITADDR  per-requester address.
REQ-011 req_din  in  NUMREQ*WIDTH  per-requester write data.
REQ-012 req_rdy  out  NUMREQ  grant; transfer when req_vld&req_rdy.
REQ-013 ready  in  1  memory ready.
REQ-014 read  out  1  memory read, slot 0.
REQ-015 write  out  2  memory write per slot.
REQ-016 addr  out  2*BITADDR  slot addresses, slot 0 in low bits.
REQ-017 din  out  2*WIDTH  slot write data.
REQ-018 rd_vld, rd_dout, rd_err  in  1, WIDTH, 1  memory read return.
REQ-019 rsp_vld  out  NUMREQ  one-hot read response to the owning requester.
REQ-020 rsp_dout, rsp_err  out  WIDTH, 1  response data and ECC error.
REQ-021 seq_err  out  1  sticky: rd_vld disagreed with the expected tag.
REQ-022 stall_cnt  out  16  stall counter (see Configuration).

Function
REQ-023 req_rdy SHALL be combinational from the current req_vld, req_wr, req_addr, the round-robin pointer and ready.
REQ-024 With ready=0, req_rdy SHALL be all zero.
REQ-025 Requesters SHALL be scanned in order rr_ptr, rr_ptr+1, ... mod NUMREQ, and each valid requester SHALL be granted if all of the following hold: fewer than 2 grants already made this cycle; it is not a second read; and its address does not equal an address already granted this cycle.
REQ-026 A requester that is skipped SHALL keep req_vld and retry; no request SHALL be dropped.
REQ-027 A granted read SHALL take slot 0; granted writes SHALL take slot 1 first, then slot 0 if no read was granted.
REQ-028 Granted operations SHALL appear on read/write/addr/din registered one cycle after the grant; unused slots SHALL have read/write=0, and addr/din SHALL hold their previous values.
REQ-029 When at least one grant occurs, rr_ptr SHALL become (last granted index + 1) mod NUMREQ; otherwise it SHALL remain unchanged.
REQ-030 Each issued read SHALL push {1, requester id} into a READ_LAT-deep tag shift register; a cycle without a read SHALL push {0, x}.
REQ-031 When the tag at the output of the shift register is valid, rsp_vld[id] SHALL equal rd_vld, and rsp_dout/rsp_err SHALL pass through combinationally.
REQ-032 rd_vld with an invalid output tag, or a valid output tag with rd_vld=0, SHALL set seq_err, which remains set until reset; in either case no rsp_vld SHALL assert.
REQ-033 End-to-end read latency SHALL be 1+READ_LAT cycles, measured from acceptance to rsp_vld.

Reset
REQ-034 While rst=0, the following SHALL be driven as shown: read=0, write=0, addr=0, din=0, rr_ptr=0, all tags invalid, seq_err=0, stall_cnt=0, req_rdy=0, rsp_vld=0.
REQ-035 Reads in flight when reset asserts SHALL be discarded; returns arriving after reset deasserts SHALL set seq_err.

Configuration
REQ-036 With SCHED_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 (saturating at 16'hFFFF) every cycle in which any req_vld bit is high with the matching req_rdy bit low.
REQ-037 With SCHED_STALL_CNT_EN undefined, stall_cnt SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-038 NUMREQ=4, all requesters issuing writes to distinct addresses every cycle, ready=1 -> exactly 2 grants per cycle, in the rotation {0,1},{2,3},{0,1}, with each requester granted every 2 cycles.
REQ-039 Requester 1 reads 0x010 and requester 2 writes 0x020 at cycle N -> cycle N+1: read=1, addr slot0=0x010, write=2'b10, addr slot1=0x020; rsp_vld=4'b0010 at N+1+READ_LAT.
REQ-040 Requesters 0 and 3 both write 0x055 with rr_ptr=0 -> only requester 0 is granted; requester 3 is granted the next cycle.
REQ-041 Requesters 0 and 1 both read, rr_ptr=0 -> only requester 0 is granted; rr_ptr=1; requester 1 is granted the next cycle.
REQ-042 ready=0 for 5 cycles with requests pending -> req_rdy=0 throughout, and stall_cnt=5 when SCHED_STALL_CNT_EN is defined.
REQ-043 Inject rd_vld=1 with no read issued -> no rsp_vld, and seq_err=1 until rst=0.
